maze_round_ctrl: RTL and testbench
==================================

Name: maze_round_ctrl

Overview:
Round sequencer for the VGA maze game. It latches a fresh wall pattern from the free-running LFSRs at the start of each round and spawns the player. It gates per-frame player movement and runs the countdown timer. It resolves collision, goal and timeout events into win/lose outcomes and keeps the score and lives counters for the seven-segment display. The position/collision datapath and the pixel renderer consume its outputs.

Parameters:
N_WALLS, 25, walls per orientation (horizontal_n*vertical_n)
TIME_INIT, 30, timer seconds loaded at spawn (≤63)
FRAMES_PER_SEC, 60, frame ticks per timer decrement (≥2)
LIVES_INIT, 3, lives at game start (1..7)

Ports:
in_clk  in  1  system clock; every register in this block is clocked on it
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame (vcnt==481, hcnt==0), synchronous to in_clk
start  in  1  level; begins a game from IDLE or GAMEOVER
pause  in  1  level; freezes movement and timer while high in PLAY
posr  in  1  level; forces respawn (same maze, no life lost)
hit  in  1  player overlaps an enabled wall or the border this frame
goal  in  1  player overlaps the end flag this frame
lfsr_h  in  N_WALLS  live horizontal-wall LFSR value
lfsr_v  in  N_WALLS  live vertical-wall LFSR value
wall_h  out  N_WALLS  latched horizontal mask; bit=0 means the wall is drawn and solid
wall_v  out  N_WALLS  latched vertical mask; same encoding as wall_h
player_load  out  1  one-cycle pulse: datapath reloads the start position
move_tick  out  1  one-cycle pulse: datapath applies vx/vy this frame
timer  out  6  seconds remaining
score  out  16  rounds won, saturating
lives  out  3  lives remaining
round_over  out  1  one-cycle pulse at the end of a round
round_won  out  1  valid with round_over; 1 = win
state  out  3  encoded FSM state, for debug and LEDs

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wall_h/wall_v all ones (no walls), timer=TIME_INIT, score=0, lives=LIVES_INIT.
  - All pulse outputs are 0 and frame_cnt=0.
- States, encoded IDLE=0, LOAD=1, SPAWN=2, PLAY=3, WIN=4, LOSE=5, GAMEOVER=6:
  - IDLE: wait. When start=1, go to LOAD.
  - LOAD: one cycle. wall_h<=lfsr_h, wall_v<=lfsr_v. Go to SPAWN.
  - SPAWN: one cycle. player_load=1, timer<=TIME_INIT, frame_cnt<=0. Go to PLAY.
  - PLAY: act only on cycles with frame_tick=1. Priority, highest first:
    1. posr → SPAWN; lives unchanged.
    2. hit → LOSE.
    3. goal → WIN.
    4. timer==0 → LOSE.
    5. pause → no action.
    6. Otherwise move_tick=1 that same cycle and frame_cnt increments. When frame_cnt==FRAMES_PER_SEC-1: frame_cnt<=0 and timer decrements.
  - WIN: one cycle. round_over=1, round_won=1, score+1 saturating at 16'hFFFF. Go to LOAD (new maze).
  - LOSE: one cycle. round_over=1, round_won=0, lives-1.
    - If the decremented value is 0, go to GAMEOVER.
    - Otherwise go to SPAWN; the maze is kept.
  - GAMEOVER: all outputs hold. When start=1: score<=0, lives<=LIVES_INIT, go to LOAD.
- Latency: an event on a frame_tick cycle produces round_over exactly 1 cycle later and player_load 2 cycles later (win path: LOAD then SPAWN, so 3 cycles).
- Timer reaching 0: the decrement to 0 still moves the player that frame. The next frame tick forces LOSE.
- Tie-breaks:
  - hit and goal together → LOSE.
  - frame_tick arriving in any non-PLAY state is ignored.
  - pause does not block hit, goal or posr detection.
- Wall masks change only in LOAD. They are stable for the whole round, so the renderer and collision logic always see the same maze.
- A reset assertion in any state returns all registers to their reset values immediately. A round in progress is abandoned with no round_over pulse.
- Width rules: timer is unsigned 6 bits and never wraps below 0. lives is unsigned 3 bits and never wraps below 0.

Decomposition:
- Package maze_pkg holds:
  - the state encoding constants;
  - N_WALLS;
  - the PLAY_FIELD constants shared with the renderer (pcount, horizontal_n, vertical_n).
- One sub-module, frame_timer: frame_cnt plus the timer down-counter, with inputs load, tick_en and outputs timer, zero.

Test Plan:
1. Release reset, start=1, lfsr_h=25'h0AAAAAA → LOAD then SPAWN. wall_h=25'h0AAAAAA, player_load pulses 2 cycles after start is sampled in IDLE, timer=30.
2. PLAY with FRAMES_PER_SEC=4: 8 frame ticks, no events → 8 move_tick pulses, timer=28.
3. hit and goal asserted on the same frame_tick → round_over=1, round_won=0 one cycle later; lives 3→2; wall_h unchanged after SPAWN.
4. goal alone → round_won=1, score 0→1; wall masks reload from new LFSR values; player_load 3 cycles after the tick.
5. Run the timer to 0 (TIME_INIT=1, FRAMES_PER_SEC=2) → 2 move ticks, then LOSE on the third tick. Repeat until lives=0 → GAMEOVER; start → score=0, lives=3.
6. pause=1 for 10 ticks → no move_tick, timer frozen. Assert reset mid-PLAY → state=IDLE, masks all ones, no round_over.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants and state encoding for the maze game round controller and renderer.
package maze_pkg;

  // Maze grid dimensions shared with the pixel renderer.
  localparam int unsigned HORIZONTAL_N = 5;
  localparam int unsigned VERTICAL_N   = 5;

  // Side length of one maze cell, in pixels.
  localparam int unsigned PCOUNT       = 16;

  // Each wall orientation has one mask bit per grid cell.
  localparam int unsigned N_WALLS      = HORIZONTAL_N * VERTICAL_N;

  // Round sequencer states. The encoding is visible on the debug/LED port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SPAWN    = 3'd2,
    ST_PLAY     = 3'd3,
    ST_WIN      = 3'd4,
    ST_LOSE     = 3'd5,
    ST_GAMEOVER = 3'd6
  } state_t;

endpackage

// File: rtl/maze_round_ctrl_frame_timer.sv
// Per-round countdown timer.
// Counts movement frames and takes one second off the timer after every
// FRAMES_PER_SEC frames. The timer stops at zero and never wraps.
module frame_timer #(
  parameter int unsigned TIME_INIT      = 30,
  parameter int unsigned FRAMES_PER_SEC = 60
) (
  input  logic       in_clk,
  input  logic       reset,
  input  logic       load,
  input  logic       tick_en,
  output logic [5:0] timer,
  output logic       zero
);

  localparam int unsigned CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_SEC - 1);

  logic [CNT_W-1:0] frame_cnt;

  // Reload at spawn; otherwise advance the frame counter on each movement frame and roll it into the seconds timer.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      timer     <= 6'(TIME_INIT);
    end else if (load) begin
      frame_cnt <= '0;
      timer     <= 6'(TIME_INIT);
    end else if (tick_en) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        if (timer != 6'd0) begin
          timer <= timer - 6'd1;
        end
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign zero = (timer == 6'd0);

endmodule

// File: rtl/maze_round_ctrl.sv
// Round sequencer for the VGA maze game.
// Latches a fresh maze at the start of each round, spawns the player, gates
// per-frame movement, runs the countdown, and turns collision/goal/timeout
// events into win/lose outcomes with score and lives bookkeeping.
module maze_round_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned TIME_INIT      = 30,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned LIVES_INIT     = 3
) (
  input  logic               in_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               posr,
  input  logic               hit,
  input  logic               goal,
  input  logic [N_WALLS-1:0] lfsr_h,
  input  logic [N_WALLS-1:0] lfsr_v,
  output logic [N_WALLS-1:0] wall_h,
  output logic [N_WALLS-1:0] wall_v,
  output logic               player_load,
  output logic               move_tick,
  output logic [5:0]         timer,
  output logic [15:0]        score,
  output logic [2:0]         lives,
  output logic               round_over,
  output logic               round_won,
  output logic [2:0]         state
);

  state_t cur_state;
  state_t next_state;
  logic   timer_zero;

  frame_timer #(
    .TIME_INIT      (TIME_INIT),
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_frame_timer (
    .in_clk  (in_clk),
    .reset   (reset),
    .load    (player_load),
    .tick_en (move_tick),
    .timer   (timer),
    .zero    (timer_zero)
  );

  assign state = cur_state;

  // State register.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state and pulse outputs; PLAY only reacts on frame ticks, with respawn > hit > goal > timeout > pause.
  always_comb begin
    next_state  = cur_state;
    move_tick   = 1'b0;
    player_load = 1'b0;
    round_over  = 1'b0;
    round_won   = 1'b0;
    unique case (cur_state)
      ST_IDLE: begin
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        next_state = ST_SPAWN;
      end
      ST_SPAWN: begin
        player_load = 1'b1;
        next_state  = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (posr) begin
            next_state = ST_SPAWN;
          end else if (hit) begin
            next_state = ST_LOSE;
          end else if (goal) begin
            next_state = ST_WIN;
          end else if (timer_zero) begin
            next_state = ST_LOSE;
          end else if (!pause) begin
            move_tick = 1'b1;
          end
        end
      end
      ST_WIN: begin
        round_over = 1'b1;
        round_won  = 1'b1;
        next_state = ST_LOAD;
      end
      ST_LOSE: begin
        round_over = 1'b1;
        next_state = (lives <= 3'd1) ? ST_GAMEOVER : ST_SPAWN;
      end
      ST_GAMEOVER: begin
        if (start) next_state = ST_LOAD;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Maze masks only change in LOAD so the whole round sees one stable maze.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      wall_h <= '1;
      wall_v <= '1;
    end else if (cur_state == ST_LOAD) begin
      wall_h <= lfsr_h;
      wall_v <= lfsr_v;
    end
  end

  // Score and lives bookkeeping: win adds a saturating point, lose takes a life, a new game restores both.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      score <= '0;
      lives <= 3'(LIVES_INIT);
    end else begin
      unique case (cur_state)
        ST_WIN: begin
          if (score != 16'hFFFF) score <= score + 16'd1;
        end
        ST_LOSE: begin
          if (lives != 3'd0) lives <= lives - 3'd1;
        end
        ST_GAMEOVER: begin
          if (start) begin
            score <= '0;
            lives <= 3'(LIVES_INIT);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Testbench for maze_round_ctrl: directed game scenarios checked every cycle
// against a behavioural game model, plus hand-computed literal expectations.
module tb_maze_round_ctrl;

  localparam int TI  = 3;
  localparam int FPS = 4;
  localparam int LI  = 3;
  localparam int NW  = 25;

  logic          in_clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          posr = 1'b0;
  logic          hit = 1'b0;
  logic          goal = 1'b0;
  logic [NW-1:0] lfsr_h = '0;
  logic [NW-1:0] lfsr_v = '0;
  logic [NW-1:0] wall_h;
  logic [NW-1:0] wall_v;
  logic          player_load;
  logic          move_tick;
  logic [5:0]    timer;
  logic [15:0]   score;
  logic [2:0]    lives;
  logic          round_over;
  logic          round_won;
  logic [2:0]    state;

  int vectors = 0;
  int miscompares = 0;
  int moveCount = 0;

  // Free-running clock.
  always #5 in_clk = ~in_clk;

  maze_round_ctrl #(
    .TIME_INIT      (TI),
    .FRAMES_PER_SEC (FPS),
    .LIVES_INIT     (LI)
  ) dut (
    .in_clk      (in_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .pause       (pause),
    .posr        (posr),
    .hit         (hit),
    .goal        (goal),
    .lfsr_h      (lfsr_h),
    .lfsr_v      (lfsr_v),
    .wall_h      (wall_h),
    .wall_v      (wall_v),
    .player_load (player_load),
    .move_tick   (move_tick),
    .timer       (timer),
    .score       (score),
    .lives       (lives),
    .round_over  (round_over),
    .round_won   (round_won),
    .state       (state)
  );

  // Game model: phase number, frames moved this round, score, lives and current maze.
  int            mPhase = 0;
  int            mMoves = 0;
  int            mScore = 0;
  int            mLives = LI;
  logic [NW-1:0] mWallH = '1;
  logic [NW-1:0] mWallV = '1;

  function automatic int modelTimer();
    return TI - (mMoves / FPS);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance the game model on each clock edge using the rules of the round.
  always @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      mPhase = 0; mMoves = 0; mScore = 0; mLives = LI;
      mWallH = '1; mWallV = '1;
    end else begin
      case (mPhase)
        0: if (start) mPhase = 1;
        1: begin mWallH = lfsr_h; mWallV = lfsr_v; mPhase = 2; end
        2: begin mMoves = 0; mPhase = 3; end
        3: if (frame_tick) begin
             if (posr) mPhase = 2;
             else if (hit) mPhase = 5;
             else if (goal) mPhase = 4;
             else if (modelTimer() == 0) mPhase = 5;
             else if (!pause) mMoves = mMoves + 1;
           end
        4: begin mScore = (mScore < 65535) ? mScore + 1 : mScore; mPhase = 1; end
        5: begin
             if (mLives > 0) mLives = mLives - 1;
             mPhase = (mLives == 0) ? 6 : 2;
           end
        6: if (start) begin mScore = 0; mLives = LI; mPhase = 1; end
        default: mPhase = 0;
      endcase
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge in_clk) begin
    logic expMove;
    expMove = (mPhase == 3) && frame_tick && !posr && !hit && !goal &&
              (modelTimer() != 0) && !pause;
    checkOutput("state", 32'(state), 32'(mPhase));
    checkOutput("wall_h", 32'(wall_h), 32'(mWallH));
    checkOutput("wall_v", 32'(wall_v), 32'(mWallV));
    checkOutput("timer", 32'(timer), 32'(modelTimer()));
    checkOutput("score", 32'(score), 32'(mScore));
    checkOutput("lives", 32'(lives), 32'(mLives));
    checkOutput("player_load", 32'(player_load), 32'(mPhase == 2));
    checkOutput("round_over", 32'(round_over), 32'((mPhase == 4) || (mPhase == 5)));
    checkOutput("round_won", 32'(round_won), 32'(mPhase == 4));
    checkOutput("move_tick", 32'(move_tick), 32'(expMove));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  // Drive one cycle of frame inputs, counting movement pulses, then drop the one-shot inputs.
  task automatic applyStimulus(input logic ft, input logic h, input logic g,
                               input logic pr, input logic pz);
    frame_tick = ft; hit = h; goal = g; posr = pr; pause = pz;
    @(negedge in_clk);
    if (move_tick) moveCount++;
    @(posedge in_clk);
    #1;
    frame_tick = 1'b0; hit = 1'b0; goal = 1'b0; posr = 1'b0;
  endtask

  // Tick frames until the round ends by timeout or the tick budget runs out.
  task automatic runToTimeout(output int moves, output logic lost);
    lost = 1'b0;
    moveCount = 0;
    for (int i = 0; i < 40 && !lost; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (round_over) lost = 1'b1;
      else idle(1);
    end
    moves = moveCount;
  endtask

  // Directed game scenarios.
  initial begin
    int   moves;
    logic lost;

    idle(3);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_wall_h", 32'(wall_h), 32'h1FFFFFF);
    checkOutput("reset_timer", 32'(timer), 32'd3);
    checkOutput("reset_lives", 32'(lives), 32'd3);
    checkOutput("reset_score", 32'(score), 32'd0);
    reset = 1'b1;

    lfsr_h = 25'h0AAAAAA;
    lfsr_v = 25'h1555555;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    checkOutput("start_to_load", 32'(state), 32'd1);
    idle(1);
    checkOutput("spawn_load_pulse", 32'(player_load), 32'd1);
    checkOutput("maze_h_latched", 32'(wall_h), 32'h0AAAAAA);
    checkOutput("maze_v_latched", 32'(wall_v), 32'h1555555);
    checkOutput("spawn_timer", 32'(timer), 32'd3);
    idle(1);

    moveCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    checkOutput("eight_moves", 32'(moveCount), 32'd8);
    checkOutput("timer_after_8", 32'(timer), 32'd1);

    lfsr_h = 25'h0F0F0F0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("hitgoal_over", 32'(round_over), 32'd1);
    checkOutput("hitgoal_won", 32'(round_won), 32'd0);
    idle(1);
    checkOutput("lose_respawn", 32'(player_load), 32'd1);
    checkOutput("lose_lives", 32'(lives), 32'd2);
    checkOutput("lose_keeps_maze", 32'(wall_h), 32'h0AAAAAA);
    idle(1);

    lfsr_h = 25'h1234567;
    lfsr_v = 25'h0FEDCBA;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("goal_over", 32'(round_over), 32'd1);
    checkOutput("goal_won", 32'(round_won), 32'd1);
    idle(1);
    checkOutput("win_score", 32'(score), 32'd1);
    checkOutput("win_no_load_yet", 32'(player_load), 32'd0);
    idle(1);
    checkOutput("win_load_3cyc", 32'(player_load), 32'd1);
    checkOutput("win_new_maze_h", 32'(wall_h), 32'h1234567);
    checkOutput("win_new_maze_v", 32'(wall_v), 32'h0FEDCBA);
    idle(1);

    runToTimeout(moves, lost);
    checkOutput("timeout1_seen", 32'(lost), 32'd1);
    checkOutput("timeout1_moves", 32'(moves), 32'd12);
    checkOutput("timeout1_won", 32'(round_won), 32'd0);
    idle(1);
    checkOutput("timeout1_lives", 32'(lives), 32'd1);
    idle(1);
    runToTimeout(moves, lost);
    checkOutput("timeout2_seen", 32'(lost), 32'd1);
    checkOutput("timeout2_moves", 32'(moves), 32'd12);
    idle(1);
    checkOutput("gameover_state", 32'(state), 32'd6);
    checkOutput("gameover_lives", 32'(lives), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("gameover_ignores_tick", 32'(state), 32'd6);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    checkOutput("restart_state", 32'(state), 32'd1);
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_lives", 32'(lives), 32'd3);
    idle(2);

    moveCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    checkOutput("pause_no_moves", 32'(moveCount), 32'd0);
    checkOutput("pause_timer", 32'(timer), 32'd3);
    checkOutput("pause_state", 32'(state), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("posr_state", 32'(state), 32'd2);
    checkOutput("posr_no_over", 32'(round_over), 32'd0);
    checkOutput("posr_lives", 32'(lives), 32'd3);
    pause = 1'b0;
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    #2;
    reset = 1'b0;
    #1;
    checkOutput("midplay_reset_state", 32'(state), 32'd0);
    checkOutput("midplay_reset_wall_h", 32'(wall_h), 32'h1FFFFFF);
    checkOutput("midplay_reset_over", 32'(round_over), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
